// File: rtl/async_rd_ptr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : async_rd_ptr_ctrl_pkg
// Description : Shared dual-clock FIFO helpers (Gray conversion, sync limits).
// Revision    : 1.0
// ============================================================================
package async_rd_ptr_ctrl_pkg;

    localparam int PTR_MAX_W       = 32;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Both conversions work on zero-extended operands, so a caller of any
    // width up to PTR_MAX_W casts in and truncates the result back out.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/async_rd_ptr_ctrl_gray_ptr_sync.sv
`default_nettype none
// ============================================================================
// Module      : gray_ptr_sync
// Description : STAGES-deep flop chain carrying a Gray pointer across domains.
// Revision    : 1.0
// ============================================================================
module gray_ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/async_rd_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : async_rd_ptr_ctrl
// Description : Read-domain pointer, empty/almost-empty/level/underflow logic.
// Revision    : 2.0
// ============================================================================
module async_rd_ptr_ctrl
    import async_rd_ptr_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic [ADDR_SIZE:0]   wr_addr_gray,
    input  logic                 rd_en,
    output logic                 rd_vld,
    output logic [ADDR_SIZE-1:0] rd_addr,
    output logic [ADDR_SIZE:0]   rd_addr_gray,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   rd_level,
    output logic                 underflow
);

    localparam int              PTR_W    = ADDR_SIZE + 1;
    localparam logic [PTR_W-1:0] AE_LEVEL = PTR_W'(AE_THRESH);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync_stages
        $error("async_rd_ptr_ctrl: SYNC_STAGES out of range");
    end
    if (AE_THRESH < 0 || AE_THRESH > (1 << ADDR_SIZE) - 1) begin : g_bad_ae_thresh
        $error("async_rd_ptr_ctrl: AE_THRESH out of range");
    end
    if (PTR_W > PTR_MAX_W) begin : g_bad_addr_size
        $error("async_rd_ptr_ctrl: ADDR_SIZE too large");
    end

    logic [PTR_W-1:0] wr_sync_gray;
    logic [PTR_W-1:0] wr_sync_bin;
    logic [PTR_W-1:0] rd_bin;
    logic [PTR_W-1:0] rd_bin_next;
    logic [PTR_W-1:0] rd_gray_next;
    logic [PTR_W-1:0] level_next;

    gray_ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wr_ptr_sync (
        .clk (rd_clk),
        .rst (rd_rst),
        .d   (wr_addr_gray),
        .q   (wr_sync_gray)
    );

    // empty is a flop, so the only combinational path from rd_en is this gate.
    assign rd_vld       = rd_en & ~empty;
    assign rd_bin_next  = rd_bin + {{ADDR_SIZE{1'b0}}, rd_vld};
    assign rd_gray_next = PTR_W'(bin2gray(PTR_MAX_W'(rd_bin_next)));
    assign wr_sync_bin  = PTR_W'(gray2bin(PTR_MAX_W'(wr_sync_gray)));
    assign level_next   = wr_sync_bin - rd_bin_next;
    assign rd_addr      = rd_bin[ADDR_SIZE-1:0];

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_bin       <= '0;
            rd_addr_gray <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
            underflow    <= 1'b0;
        end else begin
            rd_bin       <= rd_bin_next;
            rd_addr_gray <= rd_gray_next;
            empty        <= (rd_gray_next == wr_sync_gray);
            almost_empty <= (level_next <= AE_LEVEL);
            rd_level     <= level_next;
            underflow    <= rd_en & empty;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_async_rd_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_async_rd_ptr_ctrl
// Description : Scoreboard bench for the read-side pointer controller.
// Revision    : 1.0
// ============================================================================
module tb_async_rd_ptr_ctrl;

    localparam int AW = 4;
    localparam int PW = AW + 1;

    logic          clk          = 1'b0;
    logic          rst          = 1'b1;
    logic [PW-1:0] wr_addr_gray = '0;
    logic          rd_en        = 1'b0;
    logic          rd_vld;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rd_addr_gray;
    logic          empty;
    logic          almost_empty;
    logic [PW-1:0] rd_level;
    logic          underflow;

    int passed = 0;
    int total  = 0;
    int wptr   = 0;
    int rptr   = 0;

    typedef struct {
        int addr;
        int level;
    } pop_exp_t;

    pop_exp_t pop_q[$];
    int       uf_q[$];

    always #5 clk = ~clk;

    async_rd_ptr_ctrl #(
        .ADDR_SIZE   (AW),
        .SYNC_STAGES (2),
        .AE_THRESH   (2)
    ) dut (
        .rd_clk       (clk),
        .rd_rst       (rst),
        .wr_addr_gray (wr_addr_gray),
        .rd_en        (rd_en),
        .rd_vld       (rd_vld),
        .rd_addr      (rd_addr),
        .rd_addr_gray (rd_addr_gray),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level),
        .underflow    (underflow)
    );

    function automatic logic [PW-1:0] gray(input int b);
        logic [PW-1:0] x;
        x = PW'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic pop_burst(input int n);
        rd_en = 1'b1;
        repeat (n) @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    // Monitor: invariants every cycle, scoreboard pops on rd_vld / underflow.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("inv_empty_eq_level0", int'(empty), int'(rd_level == '0));
                if (empty) check("inv_empty_implies_ae", int'(almost_empty), 1);
                check("inv_level_le_16", int'(rd_level <= PW'(16)), 1);
                if (underflow) begin
                    if (uf_q.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_underflow: got pulse at addr %0d, expected none", rd_addr);
                    end else begin
                        int a;
                        a = uf_q.pop_front();
                        check("uf_addr_hold", int'(rd_addr), a);
                        check("uf_rd_vld", int'(rd_vld), 0);
                    end
                end
                if (rd_vld) begin
                    pop_exp_t      e;
                    logic [PW-1:0] pg;
                    pg = rd_addr_gray;
                    if (pop_q.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_pop: got rd_vld at addr %0d, expected none", rd_addr);
                    end else begin
                        e = pop_q.pop_front();
                        check("pop_addr", int'(rd_addr), e.addr);
                        @(posedge clk);
                        #1;
                        check("pop_level", int'(rd_level), e.level);
                        check("pop_empty", int'(empty), int'(e.level == 0));
                        check("pop_almost_empty", int'(almost_empty), int'(e.level <= 2));
                        check("pop_gray_one_bit", $countones(rd_addr_gray ^ pg), 1);
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        total++;
        $display("FAIL timeout: got no completion, expected finish");
        $display("%0d/%0d checks passed", passed, total);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_empty", int'(empty), 1);
        check("rst_almost_empty", int'(almost_empty), 1);
        check("rst_level", int'(rd_level), 0);
        check("rst_addr", int'(rd_addr), 0);
        check("rst_addr_gray", int'(rd_addr_gray), 0);
        check("rst_underflow", int'(underflow), 0);

        // Sync latency: Gray(5) = 5'b00111 visible on the third edge.
        wptr = 5;
        wr_addr_gray = 5'b00111;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("sync_empty_edge2", int'(empty), 1);
        @(posedge clk);
        #1;
        check("sync_empty_edge3", int'(empty), 0);
        check("sync_level_edge3", int'(rd_level), 5);
        check("sync_ae_edge3", int'(almost_empty), 0);

        // Drain five words with rd_en held high.
        for (int i = 0; i < 5; i++) pop_q.push_back('{addr: i, level: 4 - i});
        pop_burst(5);
        rptr = 5;
        check("drain_addr", int'(rd_addr), 5);
        check("drain_empty", int'(empty), 1);

        // Underflow: three cycles of rd_en while empty.
        repeat (3) uf_q.push_back(5);
        pop_burst(3);
        @(posedge clk);
        #1;
        check("uf_cleared", int'(underflow), 0);
        check("uf_addr_after", int'(rd_addr), 5);

        // Wrap-around: 40 writes and 40 reads in bursts of five.
        for (int b = 0; b < 8; b++) begin
            wptr += 5;
            wr_addr_gray = gray(wptr);
            repeat (3) @(posedge clk);
            #1;
            check("burst_level", int'(rd_level), 5);
            for (int i = 0; i < 5; i++) pop_q.push_back('{addr: (rptr + i) % 16, level: 4 - i});
            pop_burst(5);
            rptr += 5;
        end
        check("wrap_addr", int'(rd_addr), 13);
        check("wrap_addr_gray", int'(rd_addr_gray), 11);

        // Mid-operation asynchronous reset with seven words pending.
        wptr += 7;
        wr_addr_gray = gray(wptr);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_level", int'(rd_level), 7);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_empty", int'(empty), 1);
        check("arst_almost_empty", int'(almost_empty), 1);
        check("arst_level", int'(rd_level), 0);
        check("arst_addr", int'(rd_addr), 0);
        check("arst_addr_gray", int'(rd_addr_gray), 0);
        check("arst_underflow", int'(underflow), 0);
        wr_addr_gray = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_empty", int'(empty), 1);
        check("post_rst_level", int'(rd_level), 0);

        @(posedge clk);
        #1;
        check("pop_queue_drained", pop_q.size(), 0);
        check("uf_queue_drained", uf_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
